// File: rtl/i2s_tx.sv
// ---------------------------------------------------------------------------
// i2s_tx -- stereo I2S transmitter fed from an audio sample FIFO.
//
// Each FIFO word holds one stereo frame: [2*SAMPLE_W-1:SAMPLE_W] is left and
// [SAMPLE_W-1:0] is right, both two's complement. The block derives bclk and
// lrclk from the system clock and shifts the frame out MSB first on sdata.
// Data and lrclk change only on the bclk falling edge, so a receiver can
// sample on the rising edge. When the FIFO has nothing for the next frame,
// that frame is sent as zeros and the sticky underrun flag is raised.
//
// Build option:
//   I2S_LEFT_JUSTIFIED_EN  defined   -> left-justified framing. The MSB
//                                       leaves on the same fall as the lrclk
//                                       edge.
//                          undefined -> standard Philips I2S. The MSB leaves
//                                       one bclk after the lrclk edge.
//
// Parameters:
//   CLK_DIV   clk cycles per bclk half period (>= 2)
//   SAMPLE_W  bits per channel
//
// Ports:
//   clk_i         system clock, rising edge
//   rst_ni        asynchronous active-low reset
//   en_i          transmitter enable; a 0->1 edge also clears underrun_o
//   data_in_i     FIFO read data, valid the clk after rd_o
//   fifo_empty_i  FIFO empty flag
//   rd_o          one-clk FIFO read strobe
//   bclk_o        bit clock
//   lrclk_o       word select, 0 = left, 1 = right
//   sdata_o       serial data
//   underrun_o    sticky: a frame went out without fresh FIFO data
// ---------------------------------------------------------------------------
module i2s_tx #(
  parameter int CLK_DIV  = 2,
  parameter int SAMPLE_W = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  en_i,
  input  logic [2*SAMPLE_W-1:0] data_in_i,
  input  logic                  fifo_empty_i,
  output logic                  rd_o,
  output logic                  bclk_o,
  output logic                  lrclk_o,
  output logic                  sdata_o,
  output logic                  underrun_o
);

  localparam int FRAME_W = 2 * SAMPLE_W;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W   = $clog2(FRAME_W);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(FRAME_W - 1);
  localparam logic [IDX_W-1:0] IDX_RGT  = IDX_W'(SAMPLE_W);

  logic [DIV_W-1:0]   div_q,   div_d;
  logic               bclk_q,  bclk_d;
  logic [IDX_W-1:0]   idx_q,   idx_d;     // index of the next bit slot to start
  logic               lrclk_q, lrclk_d;
  logic               sdata_q, sdata_d;
  logic [FRAME_W-1:0] hold_q,  hold_d;
  logic [FRAME_W-1:0] shift_q, shift_d;
  logic               pf_q,    pf_d;      // prefetch decision pending
  logic               cap_q,   cap_d;     // FIFO data arrives this clk
  logic               und_q,   und_d;
  logic               en_q,    en_d;
  logic               first_q, first_d;   // next frame start is the silent one

  logic               tick;
  logic               fall;
  logic [FRAME_W-1:0] load;

  always_comb begin
    div_d   = div_q;
    bclk_d  = bclk_q;
    idx_d   = idx_q;
    lrclk_d = lrclk_q;
    sdata_d = sdata_q;
    hold_d  = hold_q;
    shift_d = shift_q;
    pf_d    = 1'b0;
    cap_d   = 1'b0;
    und_d   = und_q;
    en_d    = en_i;
    first_d = first_q;

    tick = (div_q == DIV_LAST);
    fall = tick && bclk_q;
    // The frame after reset or enable is always silent, whatever hold holds.
    load = first_q ? '0 : hold_q;

    if (!en_i) begin
      // Abandon the frame; hold survives but is never sent, since the next
      // frame after enable is silent and the following one is re-fetched.
      div_d   = '0;
      bclk_d  = 1'b0;
      idx_d   = '0;
      lrclk_d = 1'b1;
      sdata_d = 1'b0;
      shift_d = '0;
      first_d = 1'b1;
    end else begin
      if (!en_q) begin
        und_d = 1'b0;
      end

      if (tick) begin
        div_d  = '0;
        bclk_d = ~bclk_q;
      end else begin
        div_d = div_q + DIV_W'(1);
      end

      if (fall) begin
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        lrclk_d = (idx_q >= IDX_RGT);
        if (idx_q == '0) begin
`ifdef I2S_LEFT_JUSTIFIED_EN
          sdata_d = load[FRAME_W-1];
          shift_d = load << 1;
`else
          // Slot 0 still carries the previous frame's right LSB.
          sdata_d = shift_q[FRAME_W-1];
          shift_d = load;
`endif
          first_d = 1'b0;
          pf_d    = 1'b1;
        end else begin
          sdata_d = shift_q[FRAME_W-1];
          shift_d = shift_q << 1;
        end
      end
    end

    // The read decision completes even if en drops in the same clk: the
    // strobe is already on the wire, so the word is taken into hold.
    if (pf_q) begin
      if (!fifo_empty_i) begin
        cap_d = 1'b1;
      end else begin
        hold_d = '0;
        und_d  = 1'b1;
      end
    end

    if (cap_q) begin
      hold_d = data_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q   <= '0;
      bclk_q  <= 1'b0;
      idx_q   <= '0;
      lrclk_q <= 1'b1;
      sdata_q <= 1'b0;
      hold_q  <= '0;
      shift_q <= '0;
      pf_q    <= 1'b0;
      cap_q   <= 1'b0;
      und_q   <= 1'b0;
      en_q    <= 1'b0;
      first_q <= 1'b1;
    end else begin
      div_q   <= div_d;
      bclk_q  <= bclk_d;
      idx_q   <= idx_d;
      lrclk_q <= lrclk_d;
      sdata_q <= sdata_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      pf_q    <= pf_d;
      cap_q   <= cap_d;
      und_q   <= und_d;
      en_q    <= en_d;
      first_q <= first_d;
    end
  end

  // The strobe uses the empty flag of the strobe cycle itself, so a FIFO that
  // empties just then is still seen as empty.
  assign rd_o       = pf_q && !fifo_empty_i;
  assign bclk_o     = bclk_q;
  assign lrclk_o    = lrclk_q;
  assign sdata_o    = sdata_q;
  assign underrun_o = und_q;

endmodule
